instruction_fetch: RTL and testbench

Fetch stage of the RISC-V core: holds the program counter, issues word requests to instruction memory, buffers in-order responses in a small FIFO, and presents `{pc, instruction}` to decode, where the immediate generator and opcode decode consume it. A redirect (taken branch or jump, PC = base + sign-extended offset) flushes in-flight fetches and restarts at the new PC. The memory side is a local, in-order, non-backpressurable response port.

---
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: RISC-V fetch stage. It holds the PC, issues word requests to IMEM,
//   buffers in-order responses as {pc, instruction} in a small FIFO and feeds decode.
//   A redirect flushes everything in flight and restarts fetch at redirect_pc.
// Optional feature: FETCH_MISALIGN_CHECK_EN. When it is defined, a misaligned redirect
//   raises a sticky fetch_misaligned and stalls issue. When it is undefined, redirect_pc[1:0]
//   is forced to 0.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           word fetch request to IMEM
//   imem_rsp_valid/data                 in-order, non-stallable IMEM response
//   redirect_valid/pc                   taken branch/jump restart
//   fetch_valid/ready/instruction/pc    output to decode
//   fetch_misaligned                    sticky misaligned-redirect fault
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int INSTRUCTION_WIDTH = 32,
  localparam int RISC_V_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [RISC_V_DATA_WIDTH-1:0] imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [RISC_V_DATA_WIDTH-1:0] redirect_pc,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instruction,
  output logic [RISC_V_DATA_WIDTH-1:0] fetch_pc,
  output logic                         fetch_misaligned
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t                       state_q, state_d;
  logic [RISC_V_DATA_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, tgt;
  logic [CW-1:0]                out_q, out_d, stale_q, stale_d, cnt_q, cnt_d;
  logic [PW-1:0]                rd_q, rd_d, wr_q, wr_d;
  logic                         fault_q, fault_d, bad, acc, push, pop;
  logic [RISC_V_DATA_WIDTH-1:0] tag_q [FIFO_DEPTH];
  logic [RISC_V_DATA_WIDTH-1:0] tag_d [FIFO_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] ins_q [FIFO_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] ins_d [FIFO_DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad = redirect_pc[1:0] != 2'b00;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign bad = 1'b0;
`endif

  assign tgt = {redirect_pc[RISC_V_DATA_WIDTH-1:2], 2'b00};

  // Issue depends on registered counts only, so fetch_ready has no path to it.
  // A response only moves an entry from in-flight to buffered and leaves the sum
  // unchanged, so a raised request stays up until it is accepted.
  assign imem_req_valid    = state_q == RUN && !fault_q &&
                             ({1'b0, out_q} + {1'b0, cnt_q} < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr     = pc_q;
  assign acc               = imem_req_valid && imem_req_ready;
  assign push              = imem_rsp_valid && !redirect_valid && stale_q == '0;
  assign fetch_valid       = cnt_q != '0;
  assign pop               = fetch_valid && fetch_ready && !redirect_valid;
  assign fetch_pc          = fetch_valid ? tag_q[rd_q] : '0;
  assign fetch_instruction = fetch_valid ? ins_q[rd_q] : '0;
  assign fetch_misaligned  = fault_q;

  // Responses return in order, so the tag of the next kept response is tracked
  // as a running PC. It restarts at the redirect target, because every response
  // owed before the redirect is dropped by the stale counter.
  always_comb begin
    state_d  = RUN;
    pc_d     = redirect_valid ? (bad ? pc_q : tgt) : acc ? pc_q + 32'd4 : pc_q;
    rsp_pc_d = redirect_valid ? (bad ? pc_q : tgt) : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    out_d    = out_q + CW'(acc) - CW'(imem_rsp_valid);
    stale_d  = redirect_valid ? out_d : stale_q - CW'(imem_rsp_valid && stale_q != '0);
    cnt_d    = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d     = redirect_valid ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d     = redirect_valid ? '0 : pop ? nxt(rd_q) : rd_q;
    fault_d  = redirect_valid ? bad : fault_q;
    tag_d    = tag_q;
    ins_d    = ins_q;
    if (push) begin
      tag_d[wr_q] = rsp_pc_q;
      ins_d[wr_q] = imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      stale_q  <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      stale_q  <= stale_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fault_q  <= fault_d;
    end
  end

  // Storage needs no reset: the outputs are gated by fetch_valid.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    ins_q <= ins_d;
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch against an in-order IMEM model (mem[a] = ~a)
module tb_instruction_fetch;
  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instruction, fetch_pc;
  logic        fetch_misaligned;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          n_acc = 0;
  int          cyc = 0;
  logic [31:0] got_pc [$];
  logic [31:0] got_in [$];
  logic [31:0] qa [$];
  int          qd [$];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qd.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      cyc            <= 0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready) begin
        qa.push_back(imem_req_addr);
        qd.push_back(cyc + lat - 1);
      end
      if (qa.size() > 0 && qd[0] <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~qa[0];
        qa.pop_front();
        qd.pop_front();
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_valid && fetch_ready && !redirect_valid) begin
        got_pc.push_back(fetch_pc);
        got_in.push_back(fetch_instruction);
      end
      if (imem_req_valid && imem_req_ready) n_acc <= n_acc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat   = l;
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_ins", fetch_instruction, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int from, input int min_n);
    logic [31:0] e;
    check({tag, "_count"}, (got_pc.size() >= from + min_n) ? 32'd1 : 32'd0, 32'd1);
    for (int i = from; i < got_pc.size(); i++) begin
      e = base + 32'(4 * (i - from));
      check({tag, "_pc"}, got_pc[i], e);
      check({tag, "_ins"}, got_in[i], ~e);
    end
  endtask

  initial begin
    int n, s, a0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    do_reset(1);
    @(negedge clk);
    check("boot_req_valid", 32'(imem_req_valid), 32'd0);
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_0000);
      end
      if (fetch_valid) break;
    end
    check("first_fetch_latency", 32'(n), 32'd3);

    step(6);
    fetch_ready = 1'b0;
    a0 = n_acc;
    step(10);
    check("stall_accepts_le2", (n_acc - a0 <= 2) ? 32'd1 : 32'd0, 32'd1);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_fetch_valid", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    step(12);
    check_seq("seq0", 32'h0, 0, 8);

    do_reset(3);
    step(3);
    redirect_pc    = 32'h0000_0100;
    redirect_valid = 1'b1;
    @(negedge clk);
    check("rd3_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    s = got_pc.size();
    @(negedge clk);
    check("rd3_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rd3_req_addr", imem_req_addr, 32'h0000_0100);
    step(20);
    check_seq("rd3", 32'h0000_0100, s, 3);
    if (got_in.size() > s) check("rd3_first_ins", got_in[s], 32'hFFFF_FEFF);

    do_reset(1);
    step(2);
    redirect_pc    = 32'h0000_0200;
    redirect_valid = 1'b1;
    @(negedge clk);
    check("rd4_req_valid", 32'(imem_req_valid), 32'd1);
    step(1);
    redirect_valid = 1'b0;
    s = got_pc.size();
    @(negedge clk);
    check("rd4_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rd4_req_addr", imem_req_addr, 32'h0000_0200);
    step(12);
    check_seq("rd4", 32'h0000_0200, s, 5);

    redirect(32'hFFFF_FFF8);
    s = got_pc.size();
    step(12);
    check_seq("wrap", 32'hFFFF_FFF8, s, 4);

    redirect(32'h0000_0102);
    s  = got_pc.size();
    a0 = n_acc;
    step(8);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_no_issue", 32'(n_acc - a0), 32'd0);
    check("mis_no_fetch", 32'(got_pc.size() - s), 32'd0);
`else
    check("mis_flag", 32'(fetch_misaligned), 32'd0);
    check_seq("mis", 32'h0000_0100, s, 2);
`endif
    redirect(32'h0000_0104);
    s = got_pc.size();
    step(8);
    check("res_flag", 32'(fetch_misaligned), 32'd0);
    check_seq("res", 32'h0000_0104, s, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
